pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central control block for the five-stage MIPS pipeline (fetch, IF_ID, ID_EX, EX_MEM, MEM_WB). It decides each cycle whether every stage register loads, holds or is flushed, and generates the forwarding selects. A run/step/halt state machine is driven by debug commands from the UART front end. It also keeps advance and stall counters for read-back over the serial link.

## Interface
- No parameters. Register index width is 5 bits; counters are 32 bits.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- dbg_cmd_valid  in  1  debug command strobe
- dbg_cmd  in  2  00 RUN, 01 STEP, 10 HALT, 11 CLEAR
- dbg_cmd_ready  out  1  command accepted when valid&&ready
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_halt  in  1  ID holds the halt opcode
- ex_rs, ex_rt  in  5 each  source register numbers in EX
- ex_regwrite, ex_memtoreg  in  1 each  EX control bits
- ex_writereg  in  5  EX destination register
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_regwrite  in  1  MEM control bit
- mem_writereg  in  5  MEM destination register
- wb_regwrite  in  1  WB control bit
- wb_writereg  in  5  WB destination register
- pc_en, pc_sel  out  1 each  PC load; pc_sel=1 selects the branch target
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register loads
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero) into the stage
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 MEM result, 01 WB result
- state  out  2  00 HALTED, 01 RUN, 10 STEP, 11 DRAIN
- halt_done  out  1  one-cycle pulse on entering HALTED from DRAIN
- adv_count, stall_count  out  32 each  advancing cycles and load-use stall cycles

## Operation
- Reset values: state HALTED and both counters 0. All enables, flushes, pc_sel and halt_done are 0. fwd_a and fwd_b are 00. dbg_cmd_ready is 1.
- adv = (state != HALTED). When adv=0, every enable and flush is 0 and the pipeline is frozen.
- dbg_cmd_ready = 1 in HALTED and RUN, 0 in STEP and DRAIN.
- Commands accepted in HALTED:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - HALT is ignored.
  - CLEAR zeroes both counters and stays in HALTED.
- Commands accepted in RUN:
  - HALT goes to HALTED.
  - RUN, STEP and CLEAR are ignored.
- STEP lasts exactly one advancing cycle, then goes to HALTED. If id_halt=1 during that cycle, it goes to DRAIN instead.
- RUN with id_halt=1 and no accepted HALT goes to DRAIN. If a HALT command and id_halt occur in the same cycle, the HALT command wins and the state goes to HALTED.
- DRAIN:
  - Lasts exactly 4 cycles, counted by a 2-bit down-counter, then goes to HALTED with halt_done=1 for one cycle.
  - Throughout DRAIN, pc_en=0 and if_id_flush=1.
  - id_ex_en, ex_mem_en and mem_wb_en are 1, so in-flight instructions retire.
  - Hazard outputs still apply.
- Load-use stall:
  - Condition: adv, ex_regwrite, ex_memtoreg, ex_writereg!=0, and ex_writereg matches id_rs, or matches id_rt with id_uses_rt=1.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1. ex_mem_en and mem_wb_en stay 1.
  - stall_count increments.
- Taken branch:
  - Condition: adv and ex_branch_taken.
  - Response: pc_en=1, pc_sel=1, if_id_flush=1, id_ex_flush=1.
  - Takes priority over a load-use stall; in DRAIN, pc_en stays 0.
- Normal advance: all enables 1, flushes 0 (except DRAIN flush), pc_sel 0.
- id_ex_en is 1 whenever adv. A flush overrides the data in the same cycle.
- Forwarding for fwd_a (fwd_b is identical, using ex_rt):
  - 10 if mem_regwrite, mem_writereg!=0 and mem_writereg==ex_rs.
  - Otherwise 01 if wb_regwrite, wb_writereg!=0 and wb_writereg==ex_rs.
  - Otherwise 00.
  - Forwarding is computed regardless of state.
- adv_count increments on every cycle with adv=1. Both counters wrap from 0xFFFFFFFF to 0.

## Timing
- State, drain counter and the adv_count/stall_count counters are registered. Enables, flushes, pc_sel and fwd_* are combinational from the current state and the hazard inputs.
- A command accepted at edge k changes state at edge k. Outputs reflect the new state during cycle k+1.
- STEP produces exactly one cycle with adv=1.
- reset asserted mid-RUN or mid-DRAIN forces HALTED at the next edge, clears counters, and suppresses halt_done.

## Test plan
- Reset, then RUN: after reset, state=00 and all enables are 0. Accepted RUN gives state=01 next cycle, with all enables 1 and adv_count incrementing by 1 per cycle.
- Load-use stall: ex_memtoreg=1, ex_regwrite=1, ex_writereg=5, id_rs=5 in RUN. Expect pc_en=0, if_id_en=0, id_ex_flush=1, stall_count+1. The same stimulus with ex_writereg=0 gives no stall.
- Branch over stall: ex_branch_taken=1 together with the stall condition. Expect pc_sel=1, pc_en=1, if_id_flush=1, id_ex_flush=1; stall_count does not increment.
- Forwarding priority: mem_writereg=wb_writereg=ex_rs=7 with both regwrite bits 1 gives fwd_a=10. With mem_regwrite=0 it gives 01. With ex_rs=0 it gives 00.
- STEP twice from HALTED: each STEP gives exactly one cycle with state=10 and all enables 1, then HALTED. adv_count goes 0→1→2, and dbg_cmd_ready=0 during STEP.
- Halt drain and mid-drain reset: in RUN, id_halt=1 gives 4 DRAIN cycles with pc_en=0 and if_id_flush=1, then halt_done pulses once and state=00. Asserting reset in DRAIN cycle 2 gives state=00, counters 0, and no halt_done.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stage load/hold/flush control, forwarding selects,
// run/step/halt/drain debug FSM and advance/stall counters for a 5-stage MIPS.
module pipeline_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbg_cmd_valid,
  input  logic [1:0]  dbg_cmd,
  output logic        dbg_cmd_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_halt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_writereg,
  input  logic        ex_branch_taken,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_writereg,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_writereg,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic        halt_done,
  output logic [31:0] adv_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_DRAIN  = 2'b11
  } state_e;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  logic        halt_done_q, halt_done_d;
  logic [31:0] adv_count_q, adv_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  logic adv, in_drain, load_use, br_taken, cmd_acc, stall_hit;

  // Hazard detection; a taken branch squashes the stalled instruction anyway,
  // so a stall is only counted when no branch redirects in the same cycle.
  always_comb begin
    adv       = (state_q != S_HALTED);
    in_drain  = (state_q == S_DRAIN);
    load_use  = adv && ex_regwrite && ex_memtoreg && (ex_writereg != 5'd0) &&
                ((ex_writereg == id_rs) || (id_uses_rt && (ex_writereg == id_rt)));
    br_taken  = adv && ex_branch_taken;
    stall_hit = load_use && !br_taken;
    dbg_cmd_ready = (state_q == S_HALTED) || (state_q == S_RUN);
    cmd_acc   = dbg_cmd_valid && dbg_cmd_ready;
  end

  // Stage enables and flushes; everything frozen when not advancing.
  always_comb begin
    pc_en       = adv && !in_drain && !stall_hit;
    pc_sel      = br_taken;
    if_id_en    = adv && !stall_hit;
    if_id_flush = in_drain || br_taken;
    id_ex_en    = adv;
    id_ex_flush = br_taken || load_use;
    ex_mem_en   = adv;
    mem_wb_en   = adv;
  end

  // Forwarding selects: MEM result beats WB result; r0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ex_rs))
      fwd_a = 2'b10;
    else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == ex_rs))
      fwd_a = 2'b01;
    if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ex_rt))
      fwd_b = 2'b10;
    else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == ex_rt))
      fwd_b = 2'b01;
  end

  // Next-state for debug FSM, drain counter and performance counters.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    halt_done_d   = 1'b0;
    adv_count_d   = adv ? adv_count_q + 32'd1 : adv_count_q;
    stall_count_d = stall_hit ? stall_count_q + 32'd1 : stall_count_q;
    case (state_q)
      S_HALTED: begin
        if (cmd_acc) begin
          case (dbg_cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: begin
              adv_count_d   = 32'd0;
              stall_count_d = 32'd0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // An explicit HALT wins over a halt opcode arriving the same cycle.
        if (cmd_acc && (dbg_cmd == CMD_HALT)) begin
          state_d = S_HALTED;
        end else if (id_halt) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd3;
        end
      end
      S_STEP: begin
        if (id_halt) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd3;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          state_d     = S_HALTED;
          halt_done_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  // State, counters and halt_done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HALTED;
      drain_cnt_q   <= 2'd0;
      halt_done_q   <= 1'b0;
      adv_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      halt_done_q   <= halt_done_d;
      adv_count_q   <= adv_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign halt_done   = halt_done_q;
  assign adv_count   = adv_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: behavioural mode model checked every cycle,
// plus directed literal expectations for the key scenarios.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dbg_cmd_valid = 1'b0;
  logic [1:0]  dbg_cmd = 2'b00;
  logic        dbg_cmd_ready;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        id_uses_rt = 1'b0, id_halt = 1'b0;
  logic [4:0]  ex_rs = '0, ex_rt = '0, ex_writereg = '0;
  logic        ex_regwrite = 1'b0, ex_memtoreg = 1'b0, ex_branch_taken = 1'b0;
  logic        mem_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic [4:0]  mem_writereg = '0, wb_writereg = '0;
  logic        pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, halt_done;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [31:0] adv_count, stall_count;

  pipeline_sequencer dut (
    .clk(clk), .reset(reset), .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd(dbg_cmd),
    .dbg_cmd_ready(dbg_cmd_ready), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_writereg(ex_writereg),
    .ex_branch_taken(ex_branch_taken), .mem_regwrite(mem_regwrite),
    .mem_writereg(mem_writereg), .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .halt_done(halt_done), .adv_count(adv_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 halted, 1 run, 2 step, 3 drain; drain_left = DRAIN cycles remaining.
  int  m_mode = 0, m_drain_left = 0;
  bit  m_hd = 1'b0;
  logic [31:0] m_adv = 0, m_stall = 0;
  int  n_mode, n_drain_left;
  bit  n_hd;
  logic [31:0] n_adv, n_stall;

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (mem_regwrite && mem_writereg != 0 && mem_writereg == src) return 2'b10;
    if (wb_regwrite && wb_writereg != 0 && wb_writereg == src) return 2'b01;
    return 2'b00;
  endfunction

  // Compare process: check outputs against the model mid-cycle, and work out
  // what the model looks like after the coming edge.
  always @(negedge clk) begin
    bit adv, drain, lu, br, ready, acc;
    adv   = (m_mode != 0);
    drain = (m_mode == 3);
    lu    = adv && ex_regwrite && ex_memtoreg && ex_writereg != 0 &&
            (ex_writereg == id_rs || (id_uses_rt && ex_writereg == id_rt));
    br    = adv && ex_branch_taken;
    ready = (m_mode == 0 || m_mode == 1);
    if (chk_en) begin
      chk("state",       32'(state),         32'(m_mode));
      chk("halt_done",   32'(halt_done),     32'(m_hd));
      chk("adv_count",   adv_count,          m_adv);
      chk("stall_count", stall_count,        m_stall);
      chk("ready",       32'(dbg_cmd_ready), 32'(ready));
      chk("pc_en",       32'(pc_en),         32'(adv && !drain && (br || !lu)));
      chk("pc_sel",      32'(pc_sel),        32'(br));
      chk("if_id_en",    32'(if_id_en),      32'(adv && (br || !lu)));
      chk("if_id_flush", 32'(if_id_flush),   32'(drain || br));
      chk("id_ex_en",    32'(id_ex_en),      32'(adv));
      chk("id_ex_flush", 32'(id_ex_flush),   32'(br || lu));
      chk("ex_mem_en",   32'(ex_mem_en),     32'(adv));
      chk("mem_wb_en",   32'(mem_wb_en),     32'(adv));
      chk("fwd_a",       32'(fwd_a),         32'(fwd_of(ex_rs)));
      chk("fwd_b",       32'(fwd_b),         32'(fwd_of(ex_rt)));
    end
    acc          = dbg_cmd_valid && ready;
    n_mode       = m_mode;
    n_drain_left = m_drain_left;
    n_hd         = 1'b0;
    n_adv        = m_adv + (adv ? 1 : 0);
    n_stall      = m_stall + ((lu && !br) ? 1 : 0);
    if (m_mode == 0) begin
      if (acc && dbg_cmd == 2'b00) n_mode = 1;
      if (acc && dbg_cmd == 2'b01) n_mode = 2;
      if (acc && dbg_cmd == 2'b11) begin n_adv = 0; n_stall = 0; end
    end else if (m_mode == 1) begin
      if (acc && dbg_cmd == 2'b10) n_mode = 0;
      else if (id_halt) begin n_mode = 3; n_drain_left = 4; end
    end else if (m_mode == 2) begin
      if (id_halt) begin n_mode = 3; n_drain_left = 4; end
      else n_mode = 0;
    end else begin
      n_drain_left = m_drain_left - 1;
      if (n_drain_left == 0) begin n_mode = 0; n_hd = 1'b1; end
    end
    if (reset) begin
      n_mode = 0; n_drain_left = 0; n_hd = 1'b0; n_adv = 0; n_stall = 0;
    end
  end

  always @(posedge clk) begin
    m_mode       <= n_mode;
    m_drain_left <= n_drain_left;
    m_hd         <= n_hd;
    m_adv        <= n_adv;
    m_stall      <= n_stall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] c);
    dbg_cmd_valid = 1'b1;
    dbg_cmd       = c;
    tick();
    dbg_cmd_valid = 1'b0;
  endtask

  task automatic clr_hazards();
    ex_regwrite = 0; ex_memtoreg = 0; ex_writereg = 0; id_rs = 0; id_rt = 0;
    id_uses_rt = 0; ex_branch_taken = 0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    #1;
    // reset state
    chk("lit_reset_state", 32'(state), 32'd0);
    chk("lit_reset_pc_en", 32'(pc_en), 32'd0);
    chk("lit_reset_ready", 32'(dbg_cmd_ready), 32'd1);

    // RUN: three advancing cycles
    cmd(2'b00);
    chk("lit_run_state", 32'(state), 32'd1);
    tick(); tick(); tick();
    chk("lit_run_adv3", adv_count, 32'd3);

    // load-use on rs, then same with writereg 0
    ex_regwrite = 1; ex_memtoreg = 1; ex_writereg = 5; id_rs = 5;
    #1;
    chk("lit_lu_pc_en", 32'(pc_en), 32'd0);
    chk("lit_lu_flush", 32'(id_ex_flush), 32'd1);
    tick();
    chk("lit_lu_stall1", stall_count, 32'd1);
    ex_writereg = 0; id_rs = 0;
    tick();
    chk("lit_lu_r0_stall", stall_count, 32'd1);
    // load-use through rt, only when rt is used
    ex_writereg = 9; id_rt = 9; id_uses_rt = 0;
    tick();
    id_uses_rt = 1;
    tick();
    chk("lit_lu_rt_stall", stall_count, 32'd2);

    // branch together with stall
    ex_writereg = 5; id_rs = 5; ex_branch_taken = 1;
    #1;
    chk("lit_br_pc_sel", 32'(pc_sel), 32'd1);
    chk("lit_br_pc_en",  32'(pc_en), 32'd1);
    tick();
    chk("lit_br_no_stall", stall_count, 32'd2);
    clr_hazards();

    // forwarding priority
    ex_rs = 7; ex_rt = 7; mem_writereg = 7; wb_writereg = 7;
    mem_regwrite = 1; wb_regwrite = 1; #1;
    chk("lit_fwd_mem", 32'(fwd_a), 32'd2);
    mem_regwrite = 0; #1;
    chk("lit_fwd_wb", 32'(fwd_b), 32'd1);
    ex_rs = 0; #1;
    chk("lit_fwd_r0", 32'(fwd_a), 32'd0);
    tick();
    mem_regwrite = 0; wb_regwrite = 0; ex_rs = 0; ex_rt = 0;

    // HALT + id_halt together: HALT wins
    id_halt = 1;
    cmd(2'b10);
    id_halt = 0;
    chk("lit_halt_wins", 32'(state), 32'd0);
    // RUN ignored? no: HALT ignored in HALTED, then CLEAR
    cmd(2'b10);
    chk("lit_halt_ignored", 32'(state), 32'd0);
    cmd(2'b11);
    chk("lit_clear_adv", adv_count, 32'd0);
    chk("lit_clear_stall", stall_count, 32'd0);

    // STEP twice
    cmd(2'b01);
    chk("lit_step1_state", 32'(state), 32'd2);
    chk("lit_step1_ready", 32'(dbg_cmd_ready), 32'd0);
    tick();
    chk("lit_step1_adv", adv_count, 32'd1);
    chk("lit_step1_halted", 32'(state), 32'd0);
    cmd(2'b01);
    tick();
    chk("lit_step2_adv", adv_count, 32'd2);

    // halt drain
    cmd(2'b00);
    id_halt = 1;
    tick();
    id_halt = 0;
    chk("lit_drain_state", 32'(state), 32'd3);
    chk("lit_drain_iff", 32'(if_id_flush), 32'd1);
    tick(); tick(); tick();
    chk("lit_drain_c4", 32'(state), 32'd3);
    tick();
    chk("lit_drain_done", 32'(halt_done), 32'd1);
    chk("lit_drain_halted", 32'(state), 32'd0);
    tick();
    chk("lit_done_pulse", 32'(halt_done), 32'd0);

    // mid-drain reset
    cmd(2'b00);
    id_halt = 1;
    tick();
    id_halt = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("lit_rst_state", 32'(state), 32'd0);
    chk("lit_rst_adv", adv_count, 32'd0);
    tick(); tick(); tick(); tick();
    chk("lit_rst_no_done", 32'(halt_done), 32'd0);

    // STEP landing on a halt opcode drains
    cmd(2'b01);
    id_halt = 1;
    tick();
    id_halt = 0;
    chk("lit_step_drain", 32'(state), 32'd3);
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
